bus_cycle_ctrl: RTL and testbench

// Sequences one external 8085 bus machine cycle (opcode fetch, memory or I/O read/write, interrupt acknowledge) per request.

---
 rtl/bus_cycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences one 8085 bus machine cycle per request,
// with READY wait states and HOLD/HLDA bus arbitration.
module bus_cycle_ctrl #(
  parameter int MAX_WAIT   = 0,
  parameter int WAIT_CNT_W = 8
) (
  input  logic        phi1,
  input  logic        resetn,
  input  logic        cyc_req,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        cyc_ack,
  output logic        cyc_done,
  output logic [7:0]  rdata,
  output logic        timeout,
  input  logic        ready,
  input  logic        hold,
  output logic        hlda,
  input  logic [7:0]  ad_in,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic [7:0]  a_hi,
  output logic        bus_oe,
  output logic        ale,
  output logic        rdn,
  output logic        wrn,
  output logic        iomn,
  output logic        s1,
  output logic        s0,
  output logic [5:0]  t_state
);

  typedef enum logic [5:0] {
    S_TI = 6'b100000,
    S_T1 = 6'b010000,
    S_T2 = 6'b001000,
    S_TW = 6'b000100,
    S_T3 = 6'b000010,
    S_TH = 6'b000001
  } state_t;

  localparam logic [2:0] TY_MW  = 3'd2;
  localparam logic [2:0] TY_IOW = 3'd4;

  state_t                r_state;
  logic [2:0]            r_type;
  logic [7:0]            r_wdata;
  logic [WAIT_CNT_W-1:0] r_wcnt;
  logic                  r_done;
  logic                  r_tmo;
  logic [7:0]            r_rdata;
  logic                  r_hlda;
  logic [7:0]            r_ad_out;
  logic                  r_ad_oe;
  logic [7:0]            r_a_hi;
  logic                  r_bus_oe;
  logic                  r_ale;
  logic                  r_rdn;
  logic                  r_wrn;
  logic                  r_iomn;
  logic                  r_s1;
  logic                  r_s0;

  logic                  w_valid;
  logic                  w_idle;
  logic                  w_wr;
  logic                  w_force;
  logic [WAIT_CNT_W-1:0] w_cnt_nx;

  // {iomn, s1, s0} for each cycle type
  function automatic logic [2:0] status_of(input logic [2:0] t);
    logic [2:0] st;
    st = 3'b000;
    unique case (t)
      3'd0:    st = 3'b011;
      3'd1:    st = 3'b010;
      3'd2:    st = 3'b001;
      3'd3:    st = 3'b110;
      3'd4:    st = 3'b101;
      3'd5:    st = 3'b111;
      default: st = 3'b000;
    endcase
    return st;
  endfunction

  assign w_valid  = ~(cyc_type[2] & cyc_type[1]);
  assign w_idle   = (r_state == S_TI) || (r_state == S_T3);
  assign cyc_ack  = cyc_req & ~hold & w_valid & w_idle;
  assign w_wr     = (r_type == TY_MW) || (r_type == TY_IOW);
  assign w_cnt_nx = r_wcnt + 1'b1;
  assign w_force  = (MAX_WAIT != 0) &&
                    (w_cnt_nx == WAIT_CNT_W'(MAX_WAIT));

  always_ff @(posedge phi1 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_TI;
      r_type   <= 3'd0;
      r_wdata  <= 8'h00;
      r_wcnt   <= '0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_rdata  <= 8'h00;
      r_hlda   <= 1'b0;
      r_ad_out <= 8'h00;
      r_ad_oe  <= 1'b0;
      r_a_hi   <= 8'h00;
      r_bus_oe <= 1'b1;
      r_ale    <= 1'b0;
      r_rdn    <= 1'b1;
      r_wrn    <= 1'b1;
      r_iomn   <= 1'b0;
      r_s1     <= 1'b0;
      r_s0     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      unique case (r_state)
        S_TI: begin
          if (!cyc_ack && hold) begin
            r_state  <= S_TH;
            r_hlda   <= 1'b1;
            r_bus_oe <= 1'b0;
            r_ad_oe  <= 1'b0;
          end
        end
        S_T1: begin
          r_state <= S_T2;
          r_ale   <= 1'b0;
          if (w_wr) begin
            r_wrn    <= 1'b0;
            r_ad_out <= r_wdata;
            r_ad_oe  <= 1'b1;
          end else begin
            r_rdn   <= 1'b0;
            r_ad_oe <= 1'b0;
          end
        end
        S_T2: begin
          if (ready) begin
            r_state <= S_T3;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_TW;
          end
        end
        S_TW: begin
          r_wcnt <= w_cnt_nx;
          // READY wins over the limit when both land on the same edge
          if (ready || w_force) begin
            r_state <= S_T3;
            r_done  <= 1'b1;
            r_tmo   <= ~ready;
          end
        end
        S_T3: begin
          r_rdn   <= 1'b1;
          r_wrn   <= 1'b1;
          r_ad_oe <= 1'b0;
          r_wcnt  <= '0;
          if (!w_wr) r_rdata <= ad_in;
          if (!cyc_ack) begin
            if (hold) begin
              r_state  <= S_TH;
              r_hlda   <= 1'b1;
              r_bus_oe <= 1'b0;
            end else begin
              r_state <= S_TI;
            end
          end
        end
        S_TH: begin
          if (!hold) begin
            r_state  <= S_TI;
            r_hlda   <= 1'b0;
            r_bus_oe <= 1'b1;
          end
        end
        default: r_state <= S_TI;
      endcase
      if (cyc_ack) begin
        r_state  <= S_T1;
        r_type   <= cyc_type;
        r_wdata  <= cyc_wdata;
        r_ale    <= 1'b1;
        r_a_hi   <= cyc_addr[15:8];
        r_ad_out <= cyc_addr[7:0];
        r_ad_oe  <= 1'b1;
        {r_iomn, r_s1, r_s0} <= status_of(cyc_type);
      end
    end
  end

  assign cyc_done = r_done;
  assign timeout  = r_tmo;
  assign rdata    = r_rdata;
  assign hlda     = r_hlda;
  assign ad_out   = r_ad_out;
  assign ad_oe    = r_ad_oe;
  assign a_hi     = r_a_hi;
  assign bus_oe   = r_bus_oe;
  assign ale      = r_ale;
  assign rdn      = r_rdn;
  assign wrn      = r_wrn;
  assign iomn     = r_iomn;
  assign s1       = r_s1;
  assign s0       = r_s0;
  assign t_state  = r_state;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: vector table, hand-written corner sequences and
// random cycles checked against a cycle-count level reference model.
module tb_bus_cycle_ctrl;

  localparam int MW = 3;

  localparam logic [5:0] TI = 6'b100000;
  localparam logic [5:0] T1 = 6'b010000;
  localparam logic [5:0] T2 = 6'b001000;
  localparam logic [5:0] TW = 6'b000100;
  localparam logic [5:0] T3 = 6'b000010;
  localparam logic [5:0] TH = 6'b000001;

  logic        phi1;
  logic        resetn;
  logic        cyc_req;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        cyc_ack;
  logic        cyc_done;
  logic [7:0]  rdata;
  logic        timeout;
  logic        ready;
  logic        hold;
  logic        hlda;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        bus_oe;
  logic        ale;
  logic        rdn;
  logic        wrn;
  logic        iomn;
  logic        s1;
  logic        s0;
  logic [5:0]  t_state;

  int n_vec;
  int n_err;

  bus_cycle_ctrl #(.MAX_WAIT(MW), .WAIT_CNT_W(8)) dut (
    .phi1(phi1), .resetn(resetn),
    .cyc_req(cyc_req), .cyc_type(cyc_type),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .cyc_ack(cyc_ack), .cyc_done(cyc_done),
    .rdata(rdata), .timeout(timeout),
    .ready(ready), .hold(hold), .hlda(hlda),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .a_hi(a_hi), .bus_oe(bus_oe), .ale(ale),
    .rdn(rdn), .wrn(wrn), .iomn(iomn),
    .s1(s1), .s0(s0), .t_state(t_state)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  typedef struct {
    logic [2:0]  ty;
    logic [15:0] ad;
    logic [7:0]  wd;
    int          nw;
    logic [7:0]  din;
    int          len;
    bit          to;
    logic [2:0]  st;
    logic [7:0]  rd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  // Reference: cycle length, timeout, status bits and write flag
  function automatic void model(input logic [2:0] ty, input int nw,
                                output int len, output bit to,
                                output logic [2:0] st, output bit wr);
    logic [2:0] stat [6];
    int waits;
    stat = '{3'b011, 3'b010, 3'b001, 3'b110, 3'b101, 3'b111};
    waits = (nw < MW) ? nw : MW;
    len = 3 + waits;
    to = (nw > MW);
    st = stat[ty];
    wr = (ty == 3'd2) || (ty == 3'd4);
  endfunction

  task automatic run_cyc(input logic [2:0] ty, input logic [15:0] ad,
                         input logic [7:0] wd, input int nw,
                         input logic [7:0] din, input int len,
                         input bit to, input logic [2:0] st,
                         input logic [7:0] rd);
    bit wr;
    int n_rd;
    int n_wr;
    int got;
    bit got_to;
    wr = (ty == 3'd2) || (ty == 3'd4);
    n_rd = 0;
    n_wr = 0;
    got = 0;
    got_to = 1'b0;
    tick();
    cyc_req = 1'b1;
    cyc_type = ty;
    cyc_addr = ad;
    cyc_wdata = wd;
    ad_in = din;
    ready = 1'b0;
    @(negedge phi1);
    chk("ack", 32'(cyc_ack), 32'd1);
    for (int c = 1; c <= 40 && got == 0; c++) begin
      tick();
      if (c == 1) cyc_req = 1'b0;
      ready = (c >= 2 + nw);
      @(negedge phi1);
      if (!rdn) n_rd++;
      if (!wrn) n_wr++;
      if (c == 1) begin
        chk("t1_bus", 32'({ale, a_hi, ad_out, ad_oe}),
            32'({1'b1, ad, 1'b1}));
        chk("t1_status", 32'({iomn, s1, s0}), 32'(st));
      end
      if (c == 2)
        chk("t2_bus", 32'({ad_oe, wr ? ad_out : 8'h00}),
            32'({wr, wr ? wd : 8'h00}));
      if (cyc_done) begin
        got = c;
        got_to = timeout;
      end
    end
    chk("length", 32'(got), 32'(len));
    chk("timeout", 32'(got_to), 32'(to));
    chk("strobe_low", 32'(wr ? n_wr : n_rd), 32'(len - 1));
    chk("other_strobe", 32'(wr ? n_rd : n_wr), 32'd0);
    tick();
    @(negedge phi1);
    chk("rdata", 32'(rdata), 32'(rd));
    chk("idle", 32'({t_state, rdn, wrn, ale}), 32'({TI, 3'b110}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  seq [4];
    logic [7:0]  mrd;
    logic [2:0]  ty;
    logic [2:0]  st;
    int          nw;
    int          len;
    bit          to;
    bit          wr;
    logic [7:0]  din;

    n_vec = 0;
    n_err = 0;
    resetn = 1'b0;
    cyc_req = 1'b0;
    cyc_type = 3'd0;
    cyc_addr = 16'h0000;
    cyc_wdata = 8'h00;
    ready = 1'b1;
    hold = 1'b0;
    ad_in = 8'h00;

    tbl[0] = '{3'd1, 16'h1234, 8'h00, 0, 8'h5A, 3, 1'b0, 3'b010, 8'h5A};
    tbl[1] = '{3'd4, 16'h0080, 8'hC3, 2, 8'h00, 5, 1'b0, 3'b101, 8'h5A};
    tbl[2] = '{3'd0, 16'h0000, 8'h00, 1, 8'h3E, 4, 1'b0, 3'b011, 8'h3E};
    tbl[3] = '{3'd2, 16'h8001, 8'hA5, 5, 8'h00, 6, 1'b1, 3'b001, 8'h3E};
    tbl[4] = '{3'd3, 16'h00F0, 8'h00, 4, 8'h81, 6, 1'b1, 3'b110, 8'h81};
    tbl[5] = '{3'd5, 16'hFFFF, 8'h00, 3, 8'hFF, 6, 1'b0, 3'b111, 8'hFF};

    // reset state
    @(negedge phi1);
    chk("reset_ctl", 32'({t_state, ale, rdn, wrn, iomn, s1, s0}),
        32'({TI, 6'b011000}));
    chk("reset_oe", 32'({ad_oe, bus_oe, hlda, cyc_done, timeout}),
        32'(5'b01000));
    chk("reset_data", 32'({rdata, a_hi, ad_out}), 32'd0);
    tick();
    resetn = 1'b1;

    for (int i = 0; i < 6; i++)
      run_cyc(tbl[i].ty, tbl[i].ad, tbl[i].wd, tbl[i].nw, tbl[i].din,
              tbl[i].len, tbl[i].to, tbl[i].st, tbl[i].rd);

    // reserved types are never acknowledged
    tick();
    cyc_req = 1'b1;
    cyc_type = 3'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge phi1);
      chk("reserved6", 32'({cyc_ack, t_state}), 32'({1'b0, TI}));
      tick();
    end
    cyc_type = 3'd7;
    @(negedge phi1);
    chk("reserved7", 32'({cyc_ack, t_state}), 32'({1'b0, TI}));
    tick();
    cyc_req = 1'b0;

    // HOLD raised in T2 of an opcode fetch
    cyc_req = 1'b1;
    cyc_type = 3'd0;
    cyc_addr = 16'h2000;
    ad_in = 8'h77;
    @(negedge phi1);
    chk("hold_ack", 32'(cyc_ack), 32'd1);
    tick();
    cyc_req = 1'b0;
    tick();
    hold = 1'b1;
    ready = 1'b1;
    @(negedge phi1);
    chk("hold_t2", 32'({t_state, hlda}), 32'({T2, 1'b0}));
    tick();
    @(negedge phi1);
    chk("hold_t3", 32'({t_state, cyc_done, hlda}), 32'({T3, 2'b10}));
    tick();
    cyc_req = 1'b1;
    cyc_type = 3'd1;
    cyc_addr = 16'h4321;
    @(negedge phi1);
    chk("hold_th", 32'({t_state, hlda, bus_oe, ad_oe, cyc_ack}),
        32'({TH, 4'b1000}));
    chk("hold_rdata", 32'(rdata), 32'h77);
    tick();
    hold = 1'b0;
    @(negedge phi1);
    chk("hold_drop", 32'({t_state, hlda, cyc_ack}), 32'({TH, 2'b10}));
    tick();
    @(negedge phi1);
    chk("hold_ti", 32'({t_state, hlda, bus_oe, cyc_ack}),
        32'({TI, 3'b011}));
    tick();
    cyc_req = 1'b0;
    @(negedge phi1);
    chk("hold_t1", 32'({t_state, ale, a_hi}), 32'({T1, 1'b1, 8'h43}));
    tick();
    tick();
    @(negedge phi1);
    chk("hold_done", 32'({t_state, cyc_done}), 32'({T3, 1'b1}));
    tick();

    // random cycles against the reference model
    mrd = 8'h77;
    for (int i = 0; i < 40; i++) begin
      ty = 3'($urandom_range(5));
      nw = int'($urandom_range(6));
      din = 8'($urandom);
      model(ty, nw, len, to, st, wr);
      if (!wr) mrd = din;
      run_cyc(ty, 16'($urandom), 8'($urandom), nw, din, len, to, st, mrd);
      repeat ($urandom_range(2)) tick();
    end

    // back-to-back requests, then reset in a wait state
    seq = '{T1, T2, T3, T1};
    tick();
    cyc_req = 1'b1;
    cyc_type = 3'd1;
    cyc_addr = 16'h1111;
    ready = 1'b1;
    ad_in = 8'h22;
    @(negedge phi1);
    chk("b2b_ack", 32'(cyc_ack), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) ready = 1'b0;
      @(negedge phi1);
      chk("b2b_state", 32'(t_state), 32'(seq[c]));
      if (c == 2) chk("b2b_ack_t3", 32'(cyc_ack), 32'd1);
    end
    tick();
    cyc_req = 1'b0;
    @(negedge phi1);
    chk("b2b_t2", 32'({t_state, rdata}), 32'({T2, 8'h22}));
    tick();
    @(negedge phi1);
    chk("b2b_tw", 32'({t_state, rdn}), 32'({TW, 1'b0}));
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_mid", 32'({t_state, rdn, wrn, ale, cyc_done}),
        32'({TI, 4'b1100}));
    chk("rst_rdata", 32'(rdata), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
